// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures control bundles and ID-stage operands for EX,
// with stall (hold) and flush (bubble). Optional perf counters under IDEX_PERF_CNT_EN.
module id_ex_reg #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [10:0]     EX_signal_in,
  input  logic [4:0]      MEM_signal_in,
  input  logic [4:0]      WB_signal_in,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic [REGW-1:0] id_rd,
  input  logic [2:0]      id_funct3,
  output logic            ex_valid,
  output logic [10:0]     EX_signal_out,
  output logic [4:0]      MEM_signal_out,
  output logic [4:0]      WB_signal_out,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [REGW-1:0] ex_rs1,
  output logic [REGW-1:0] ex_rs2,
  output logic [REGW-1:0] ex_rd,
  output logic [2:0]      ex_funct3,
  output logic [31:0]     bubble_cnt,
  output logic [31:0]     stall_cnt
);

  // Reset and flush both produce an all-zero bubble; reset simply wins the priority.
  logic clear;
  assign clear = !rst_n || flush;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clear) begin
      // NOTE: every pipeline field is reset, not just valid, so EX never sees stale operands.
      ex_valid       <= 1'b0;
      EX_signal_out  <= '0;
      MEM_signal_out <= '0;
      WB_signal_out  <= '0;
      ex_pc          <= '0;
      ex_rs1_data    <= '0;
      ex_rs2_data    <= '0;
      ex_imm         <= '0;
      ex_rs1         <= '0;
      ex_rs2         <= '0;
      ex_rd          <= '0;
      ex_funct3      <= '0;
    end else if (!stall) begin
      // An invalid ID slot must not carry live control into EX, whatever the mux sent.
      ex_valid       <= id_valid;
      EX_signal_out  <= id_valid ? EX_signal_in  : '0;
      MEM_signal_out <= id_valid ? MEM_signal_in : '0;
      WB_signal_out  <= id_valid ? WB_signal_in  : '0;
      ex_pc          <= id_pc;
      ex_rs1_data    <= id_rs1_data;
      ex_rs2_data    <= id_rs2_data;
      ex_imm         <= id_imm;
      ex_rs1         <= id_rs1;
      ex_rs2         <= id_rs2;
      ex_rd          <= id_rd;
      ex_funct3      <= id_funct3;
    end
  end

`ifdef IDEX_PERF_CNT_EN
  logic [31:0] bubble_cnt_q;
  logic [31:0] stall_cnt_q;
  logic        bubble_ev;
  logic        stall_ev;

  assign bubble_ev = flush || (!stall && !id_valid);
  assign stall_ev  = stall && !flush;

  // Saturating counters: they pin at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      if (bubble_ev && (bubble_cnt_q != '1)) bubble_cnt_q <= bubble_cnt_q + 32'd1;
      if (stall_ev && (stall_cnt_q != '1))   stall_cnt_q  <= stall_cnt_q + 32'd1;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`else
  assign bubble_cnt = '0;
  assign stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: a behavioural model checked every cycle,
// plus directed vectors with literal expectations.
module tb_id_ex_reg;
  localparam int XLEN = 32;
  localparam int REGW = 5;
`ifdef IDEX_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, stall, flush, id_valid;
  logic [10:0] EX_signal_in;
  logic [4:0]  MEM_signal_in, WB_signal_in;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [REGW-1:0] id_rs1, id_rs2, id_rd;
  logic [2:0] id_funct3;

  logic ex_valid;
  logic [10:0] EX_signal_out;
  logic [4:0]  MEM_signal_out, WB_signal_out;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [REGW-1:0] ex_rs1, ex_rs2, ex_rd;
  logic [2:0] ex_funct3;
  logic [31:0] bubble_cnt, stall_cnt;

  id_ex_reg #(.XLEN(XLEN), .REGW(REGW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .EX_signal_in(EX_signal_in), .MEM_signal_in(MEM_signal_in), .WB_signal_in(WB_signal_in),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
    .ex_valid(ex_valid), .EX_signal_out(EX_signal_out), .MEM_signal_out(MEM_signal_out),
    .WB_signal_out(WB_signal_out), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_funct3(ex_funct3), .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Model view of the EX stage: what the pipeline slot should contain.
  typedef struct packed {
    logic            valid;
    logic [10:0]     ex_b;
    logic [4:0]      mem_b;
    logic [4:0]      wb_b;
    logic [XLEN-1:0] pc, rs1_data, rs2_data, imm;
    logic [REGW-1:0] rs1, rs2, rd;
    logic [2:0]      funct3;
    logic [31:0]     bubbles, stalls;
  } slot_t;

  slot_t m;
  bit    m_known = 1'b0;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m = '0;
      m_known = 1'b1;
    end else if (flush) begin
      m = '{bubbles: m.bubbles, stalls: m.stalls, default: '0};
      if (PERF) m.bubbles = sat_inc(m.bubbles);
    end else if (stall) begin
      if (PERF) m.stalls = sat_inc(m.stalls);
    end else begin
      m.valid    = id_valid;
      m.ex_b     = id_valid ? EX_signal_in  : 11'd0;
      m.mem_b    = id_valid ? MEM_signal_in : 5'd0;
      m.wb_b     = id_valid ? WB_signal_in  : 5'd0;
      m.pc       = id_pc;
      m.rs1_data = id_rs1_data;
      m.rs2_data = id_rs2_data;
      m.imm      = id_imm;
      m.rs1      = id_rs1;
      m.rs2      = id_rs2;
      m.rd       = id_rd;
      m.funct3   = id_funct3;
      if (PERF && !id_valid) m.bubbles = sat_inc(m.bubbles);
    end
  end

  slot_t dut_view;
  assign dut_view = '{valid: ex_valid, ex_b: EX_signal_out, mem_b: MEM_signal_out,
                      wb_b: WB_signal_out, pc: ex_pc, rs1_data: ex_rs1_data,
                      rs2_data: ex_rs2_data, imm: ex_imm, rs1: ex_rs1, rs2: ex_rs2,
                      rd: ex_rd, funct3: ex_funct3, bubbles: bubble_cnt, stalls: stall_cnt};

  always @(negedge clk) begin
    if (m_known) begin
      n_cmp++;
      if (dut_view !== m) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t got=%h exp=%h", $time, dut_view, m);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_inputs();
    EX_signal_in = '0; MEM_signal_in = '0; WB_signal_in = '0;
    id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_funct3 = '0;
  endtask

  initial begin
    // Reset with every input driven high.
    rst_n = 1'b0; stall = 1'b1; flush = 1'b1; id_valid = 1'b1;
    EX_signal_in = '1; MEM_signal_in = '1; WB_signal_in = '1;
    id_pc = '1; id_rs1_data = '1; id_rs2_data = '1; id_imm = '1;
    id_rs1 = '1; id_rs2 = '1; id_rd = '1; id_funct3 = '1;
    tick();
    check("rst_valid", ex_valid, 0);
    check("rst_ex", EX_signal_out, 0);
    check("rst_pc", ex_pc, 0);
    check("rst_rd", ex_rd, 0);
    check("rst_cnt", {bubble_cnt, stall_cnt}, 0);
    tick();

    // First load after reset.
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0; zero_inputs();
    EX_signal_in = 11'h5A5; MEM_signal_in = 5'h13; WB_signal_in = 5'h0B;
    id_pc = 32'h0000_0040; id_valid = 1'b1;
    tick();
    check("load_ex", EX_signal_out, 11'h5A5);
    check("load_mem", MEM_signal_out, 5'h13);
    check("load_wb", WB_signal_out, 5'h0B);
    check("load_pc", ex_pc, 32'h40);
    check("load_valid", ex_valid, 1);

    // Stall holds ex_rd for three cycles.
    id_rd = 5'd7;
    tick();
    check("rd_load", ex_rd, 7);
    stall = 1'b1; id_rd = 5'd9;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rd_hold", ex_rd, 7);
    end
    stall = 1'b0;
    tick();
    check("rd_release", ex_rd, 9);

    // Flush wins over stall.
    EX_signal_in = 11'h7FF; flush = 1'b1; stall = 1'b1;
    tick();
    check("flush_ex", EX_signal_out, 0);
    check("flush_valid", ex_valid, 0);
    check("flush_pc", ex_pc, 0);
    flush = 1'b0; stall = 1'b0;

    // Invalid load: bundles zeroed, data still loads.
    id_valid = 1'b0; WB_signal_in = 5'h1F; id_imm = 32'hFFFF_F000;
    tick();
    check("inv_wb", WB_signal_out, 0);
    check("inv_valid", ex_valid, 0);
    check("inv_imm", ex_imm, 32'hFFFF_F000);

    // Zeroed bundles with id_valid=1 load as-is; then a sweep of patterns.
    id_valid = 1'b1; zero_inputs(); id_rs1 = 5'd31; id_funct3 = 3'd5;
    tick();
    check("zero_bundle_valid", ex_valid, 1);
    for (int i = 0; i < 8; i++) begin
      EX_signal_in = 11'(i * 11'h123); MEM_signal_in = 5'(i * 3 + 1);
      WB_signal_in = 5'(31 - i); id_pc = 32'h1000 + 32'(i * 4);
      id_rs1_data = 32'hA5A5_0000 | 32'(i); id_rs2_data = ~id_rs1_data;
      id_imm = 32'(-i); id_rs1 = 5'(i); id_rs2 = 5'(i + 8); id_rd = 5'(i + 16);
      id_funct3 = 3'(i); id_valid = (i != 3); stall = (i == 5);
      tick();
    end
    stall = 1'b0; id_valid = 1'b1;

    // Reset mid-stall.
    zero_inputs(); id_pc = 32'h100; EX_signal_in = 11'h0F0; WB_signal_in = 5'h01;
    tick();
    check("pre_stall_pc", ex_pc, 32'h100);
    stall = 1'b1; id_pc = 32'h200;
    tick();
    check("stall_pc", ex_pc, 32'h100);
    rst_n = 1'b0;
    tick();
    check("mid_rst_pc", ex_pc, 0);
    check("mid_rst_bundles", {EX_signal_out, MEM_signal_out, WB_signal_out}, 0);
    rst_n = 1'b1; stall = 1'b0;

    // Counter sequence: 4 stalls, 2 flushes, 1 invalid load.
    stall = 1'b1;
    repeat (4) tick();
    stall = 1'b0; flush = 1'b1;
    repeat (2) tick();
    flush = 1'b0; id_valid = 1'b0;
    tick();
    id_valid = 1'b1;
    tick();
    check("stall_cnt", stall_cnt, PERF ? 4 : 0);
    check("bubble_cnt", bubble_cnt, PERF ? 3 : 0);

`ifdef IDEX_PERF_CNT_EN
    force dut.bubble_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.bubble_cnt_q;
    m.bubbles = 32'hFFFF_FFFF;
    flush = 1'b1;
    tick();
    check("bubble_sat", bubble_cnt, 32'hFFFF_FFFF);
    flush = 1'b0;
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
